// File: rtl/dec38_seq.sv
// dec38_seq: sequenced 3-to-8 decoder.
// Accepts {idc, code} entries through a valid/ready handshake into a small
// FIFO. Each entry is then replayed as a one-hot 8-bit pattern for HOLD
// cycles, followed by GAP all-zero cycles.
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid/in_ready  : input handshake
//   in_code, in_idc    : encoded index and code-valid flag (idc=0 -> all-zero slot)
//   y, y_valid         : registered decoded pattern and slot indicator
//   busy               : FSM active or FIFO non-empty
//   count              : FIFO occupancy 0..DEPTH
module dec38_seq #(
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_code,
  input  logic                     in_idc,
  output logic [7:0]               y,
  output logic                     y_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLD + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    y_q, y_d;
  logic          yv_q, yv_d;
  logic          push, pop;
  logic [3:0]    head;
  logic [7:0]    head_dec;

  assign head     = mem[rptr_q];
  assign head_dec = head[3] ? (8'h01 << head[2:0]) : 8'h00;

  // No pass-through when full: a same-cycle pop does not open the input.
  assign in_ready = rst_n && (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  assign busy    = (state_q != S_IDLE) || (count_q != '0);
  assign count   = count_q;
  assign y       = y_q;
  assign y_valid = yv_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    y_d     = y_q;
    yv_d    = yv_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          y_d     = head_dec;
          yv_d    = 1'b1;
          hold_d  = HW'(HOLD - 1);
          state_d = S_HOLD;
        end else begin
          y_d  = '0;
          yv_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          if (GAP > 0) begin
            y_d     = '0;
            yv_d    = 1'b0;
            gap_d   = GW'((GAP > 0) ? GAP - 1 : 0);
            state_d = S_GAP;
          end else if (count_q != '0) begin
            // Back-to-back reload without leaving HOLD.
            pop    = 1'b1;
            y_d    = head_dec;
            yv_d   = 1'b1;
            hold_d = HW'(HOLD - 1);
          end else begin
            y_d     = '0;
            yv_d    = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      S_GAP: begin
        y_d  = '0;
        yv_d = 1'b0;
        if (gap_q == '0) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            y_d     = head_dec;
            yv_d    = 1'b1;
            hold_d  = HW'(HOLD - 1);
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {in_idc, in_code};
  end

endmodule

// File: tb/tb_dec38_seq.sv
module tb_dec38_seq;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  // main instance (HOLD=4, GAP=1)
  logic       in_valid = 1'b0, in_idc = 1'b0;
  logic [2:0] in_code = '0;
  logic       in_ready, y_valid, busy;
  logic [7:0] y;
  logic [2:0] count;
  // GAP=0 instance
  logic       v0 = 1'b0, i0 = 1'b0;
  logic [2:0] c0 = '0;
  logic       r0, yv0, b0;
  logic [7:0] y0;
  logic [2:0] cnt0;

  int checks = 0;
  int failures = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_z[$];
  int         slot[2];
  logic [7:0] cur[2];

  always #5 clk = ~clk;

  dec38_seq #(.HOLD(4), .GAP(1), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_idc(in_idc), .y(y), .y_valid(y_valid),
    .busy(busy), .count(count)
  );

  dec38_seq #(.HOLD(4), .GAP(0), .DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0),
    .in_code(c0), .in_idc(i0), .y(y0), .y_valid(yv0),
    .busy(b0), .count(cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dec(input logic idc, input logic [2:0] code);
    logic [7:0] one;
    one = 8'h01;
    return idc ? (one << code) : 8'h00;
  endfunction

  // Scoreboard monitor: every y_valid slot lasts HOLD cycles and carries the
  // next expected pattern; y is zero outside slots.
  task automatic mon(input int k, input logic [7:0] yy, input logic vv);
    int qs;
    if (vv) begin
      if (slot[k] == 0) begin
        qs = (k == 0) ? q_m.size() : q_z.size();
        chk(k == 0 ? "sb_underflow_m" : "sb_underflow_z", qs == 0, 0);
        if (qs != 0) cur[k] = (k == 0) ? q_m.pop_front() : q_z.pop_front();
      end
      chk(k == 0 ? "slot_y_m" : "slot_y_z", yy, cur[k]);
      slot[k]++;
      if (slot[k] == HOLD) slot[k] = 0;
    end else begin
      if (slot[k] != 0) begin
        chk(k == 0 ? "slot_len_m" : "slot_len_z", slot[k], HOLD);
        slot[k] = 0;
      end
      chk(k == 0 ? "idle_zero_m" : "idle_zero_z", yy, 0);
    end
  endtask

  task automatic tick();
    logic x0, x1, rs;
    logic [7:0] e0, e1;
    #1;
    x0 = in_valid && in_ready;
    x1 = v0 && r0;
    rs = rst_n;
    e0 = dec(in_idc, in_code);
    e1 = dec(i0, c0);
    @(posedge clk);
    #1;
    if (!rs) begin
      q_m.delete();
      q_z.delete();
      slot[0] = 0;
      slot[1] = 0;
    end else begin
      if (x0) q_m.push_back(e0);
      if (x1) q_z.push_back(e1);
    end
    mon(0, y, y_valid);
    mon(1, y0, yv0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((busy || b0) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, busy || b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, maxc;
    bit saw_full, saw_rerise, acc;
    slot[0] = 0; slot[1] = 0; cur[0] = '0; cur[1] = '0;

    // 1. reset with a pending offer
    rst_n = 1'b0; in_valid = 1'b1; in_code = 3'd3; in_idc = 1'b1;
    tick(); tick();
    chk("rst_y", y, 8'h00);
    chk("rst_yv", y_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_count", count, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel_ready", in_ready, 1);
    tick();
    chk("rel_yv", y_valid, 0);
    chk("rel_busy", busy, 0);
    chk("rel_count", count, 0);

    // 2. single entry code=5
    in_valid = 1'b1; in_code = 3'd5; in_idc = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t2_count_after_push", count, 1);
    chk("t2_yv_t", y_valid, 0);
    for (int i = 0; i < HOLD; i++) begin
      tick();
      chk("t2_y", y, 8'h20);
      chk("t2_yv", y_valid, 1);
    end
    tick();
    chk("t2_gap_yv", y_valid, 0);
    chk("t2_gap_y", y, 8'h00);
    chk("t2_gap_busy", busy, 1);
    tick();
    chk("t2_idle_busy", busy, 0);

    // 3. idc=0 slot
    in_valid = 1'b1; in_code = 3'd7; in_idc = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      tick();
      chk("t3_yv", y_valid, 1);
      chk("t3_y", y, 8'h00);
    end
    tick();
    chk("t3_gap_yv", y_valid, 0);
    chk("t3_gap_busy", busy, 1);
    tick();
    chk("t3_idle_busy", busy, 0);

    // 4. burst 0..5 with in_valid held high
    idx = 0; maxc = 0; saw_full = 0; saw_rerise = 0;
    for (int cyc = 0; cyc < 200 && idx < 6; cyc++) begin
      in_valid = 1'b1; in_code = idx[2:0]; in_idc = 1'b1;
      #1;
      acc = in_ready;
      if (int'(count) > maxc) maxc = int'(count);
      if (count == 3'd4) begin
        chk("t4_full_ready_low", in_ready, 0);
        saw_full = 1;
      end else if (saw_full && in_ready) saw_rerise = 1;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("t4_all_sent", idx, 6);
    chk("t4_max_count", maxc, 4);
    chk("t4_saw_full", saw_full, 1);
    chk("t4_rerise", saw_rerise, 1);
    drain("t4_drain");
    chk("t4_sb_empty", q_m.size(), 0);

    // 5. GAP=0 instance, codes 3,3 back-to-back
    v0 = 1'b1; c0 = 3'd3; i0 = 1'b1;
    tick();
    chk("t5_first_yv", yv0, 0);
    tick();
    v0 = 1'b0;
    chk("t5_y_0", y0, 8'h08);
    chk("t5_yv_0", yv0, 1);
    for (int i = 1; i < 2 * HOLD; i++) begin
      tick();
      chk("t5_y", y0, 8'h08);
      chk("t5_yv", yv0, 1);
    end
    tick();
    chk("t5_end_yv", yv0, 0);
    chk("t5_end_y", y0, 8'h00);
    chk("t5_end_busy", b0, 0);
    chk("t5_sb_empty", q_z.size(), 0);

    // 6. reset on the 2nd HOLD cycle with two entries queued
    in_valid = 1'b1; in_idc = 1'b1; in_code = 3'd2;
    tick();
    in_code = 3'd4;
    tick();
    in_code = 3'd6;
    tick();
    in_valid = 1'b0;
    chk("t6_pre_count", count, 2);
    chk("t6_pre_y", y, 8'h04);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_y", y, 8'h00);
    chk("t6_rst_yv", y_valid, 0);
    chk("t6_rst_count", count, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_residual", y_valid, 0);
    end
    in_valid = 1'b1; in_code = 3'd1; in_idc = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_new_y", y, 8'h02);
    chk("t6_new_yv", y_valid, 1);
    drain("t6_drain");
    chk("t6_sb_empty", q_m.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec38_seq.md
Name: dec38_seq

Overview:
- Sequenced 3-to-8 decoder: the output-side counterpart of the 8-to-3 priority encoder.
- Accepts encoded indices (3-bit code plus a code-valid indicator, the encoder's idc) through a valid/ready handshake and buffers them in a small FIFO.
- Replays each index as a one-hot 8-bit pattern held for a fixed number of cycles, with an optional all-zero gap between patterns.
- Drives LED/one-hot downstream logic from a stream of encoder results.

Parameters:
HOLD, 4, cycles each decoded pattern is driven; legal range >= 1
GAP, 1, all-zero cycles inserted after each pattern; legal range >= 0
DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  producer offers {in_idc, in_code}
in_ready  out  1  block can accept this cycle
in_code  in  3  encoded index 0..7
in_idc  in  1  1: code meaningful; 0: emit all-zero pattern
y  out  8  decoded one-hot pattern (registered)
y_valid  out  1  y carries a pattern slot (high for every HOLD cycle, including idc=0 slots)
busy  out  1  FSM not in IDLE, or FIFO non-empty
count  out  $clog2(DEPTH)+1  FIFO occupancy 0..DEPTH

Behaviour:
- Reset:
  - Sampled only on the rising clk edge while rst_n=0.
  - Clears FIFO pointers and count to 0, FSM to IDLE, hold/gap counters to 0, y=8'h00, y_valid=0.
  - in_ready is forced 0 while rst_n=0; it returns to 1 the first cycle after release.
  - Reset mid-HOLD or mid-GAP aborts immediately and drops all queued entries.
- Handshake:
  - A transfer occurs on an edge where in_valid=1 and in_ready=1.
  - in_ready = rst_n && (count < DEPTH), with no full-pass-through: when full, in_ready=0 even if a pop occurs that cycle.
  - in_code and in_idc are don't-care when in_valid=0.
  - Simultaneous push and pop leave count unchanged.
  - The write pointer and read pointer wrap modulo DEPTH.
- Decode rule: y = in_idc ? (8'b1 << in_code) : 8'h00. Exactly one bit is set when idc=1.
- FSM states: IDLE, HOLD, GAP.
  - IDLE: if count != 0, pop at this edge, load y from the popped entry, set y_valid=1, load hold counter with HOLD-1, go to HOLD. Otherwise y=0, y_valid=0.
  - HOLD: y and y_valid are stable. Decrement the hold counter each edge. At counter == 0 (the last HOLD cycle):
    - GAP>0: y=0, y_valid=0, load gap counter GAP-1, go to GAP.
    - GAP=0 and count != 0: pop and reload directly, staying in HOLD (back-to-back, no bubble).
    - GAP=0 and FIFO empty: y=0, y_valid=0, go to IDLE.
  - GAP: y=0, y_valid=0, decrement the gap counter. At counter == 0:
    - count != 0: pop, load y, set y_valid=1, go to HOLD.
    - Otherwise go to IDLE.
- Timing:
  - Latency: an entry accepted at edge t into an empty, idle block is popped at edge t+1. y is valid from t+1 for exactly HOLD cycles.
  - Steady-state throughput: one entry per HOLD+GAP cycles.
- Width rules:
  - Hold counter is $clog2(HOLD+1) bits; gap counter is $clog2(GAP+1) bits (minimum 1).
  - The GAP=0 case must elaborate without the GAP state ever being entered.
- Ordering: strictly FIFO. No entry is dropped or duplicated while rst_n=1.
- busy is combinational from state and count.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1, in_code=3 -> y=00, y_valid=0, in_ready=0, count=0. The cycle after release: in_ready=1, no output activity.
2. Single entry (code=5, idc=1) accepted at edge t -> y=8'h20 and y_valid=1 for edges t+1..t+4. Then y=00, y_valid=0 at t+5 (GAP). IDLE with busy=0 from t+6.
3. idc=0 (code=7) -> y=00 with y_valid=1 for exactly 4 cycles, then the gap cycle, then IDLE.
4. Burst of codes 0..5, in_valid held high -> count reaches 4 and in_ready drops while full. y sequence is 01,02,04,08,10,20, each held 4 cycles and separated by one zero cycle. All 6 are delivered in order; in_ready re-rises as entries pop.
5. GAP=0 instance: codes 3,3 pushed back-to-back -> y=8'h08 with y_valid=1 for 8 consecutive cycles, no bubble, then IDLE.
6. rst_n=0 on the 2nd HOLD cycle with 2 entries queued -> at that edge y=00, y_valid=0, count=0. After release no residual pattern appears; a new push of code=1 yields y=8'h02 normally.
